// File: rtl/rv32i_types.sv
// Shared machine constants for the rename stage: superscalar width and
// physical register file geometry.
package rv32i_types;
   localparam int WAY       = 2;
   localparam int PRF_ENTRY = 64;
   localparam int PRF_WIDTH = $clog2(PRF_ENTRY);
   typedef logic [PRF_WIDTH-1:0] phy_tag_t;
endpackage

// File: rtl/free_list.sv
// Physical register free list: circular buffer with compacted multi-way
// dequeue at rename, compacted enqueue at commit, and flush rollback.
module free_list #(
   parameter int PRF_ENTRY = rv32i_types::PRF_ENTRY,
   parameter int PRF_WIDTH = $clog2(PRF_ENTRY),
   parameter int WAY       = rv32i_types::WAY
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [WAY-1:0]                deq_req,
   output logic [WAY-1:0][PRF_WIDTH-1:0] deq_phy,
   output logic                          deq_ready,
   input  logic [WAY-1:0]                enq_valid,
   input  logic [WAY-1:0][PRF_WIDTH-1:0] enq_phy,
   input  logic [WAY-1:0]                commit_alloc,
   input  logic                          flush,
   output logic [PRF_WIDTH:0]            free_count
);

   logic [PRF_WIDTH-1:0] mem_q [PRF_ENTRY];
   logic [PRF_WIDTH-1:0] mem_d [PRF_ENTRY];
   logic [PRF_WIDTH-1:0] head_q, head_d, tail_q, tail_d, ret_q, ret_d;
   logic [PRF_WIDTH:0]   free_count_q, free_count_d;
   logic [PRF_WIDTH:0]   deq_cnt, enq_cnt, ca_cnt;
   logic [WAY-1:0][PRF_WIDTH-1:0] deq_off, enq_off;
   logic                 deq_fire;

   // Exclusive prefix counts give each slot its compacted offset.
   always_comb begin
      deq_cnt = '0;
      enq_cnt = '0;
      ca_cnt  = '0;
      deq_off = '0;
      enq_off = '0;
      for (int i = 0; i < WAY; i++) begin
         deq_off[i] = deq_cnt[PRF_WIDTH-1:0];
         enq_off[i] = enq_cnt[PRF_WIDTH-1:0];
         deq_cnt    = deq_cnt + (PRF_WIDTH+1)'(deq_req[i]);
         enq_cnt    = enq_cnt + (PRF_WIDTH+1)'(enq_valid[i]);
         ca_cnt     = ca_cnt + (PRF_WIDTH+1)'(commit_alloc[i]);
      end
   end

   assign free_count = free_count_q;
   assign deq_ready  = free_count_q >= (PRF_WIDTH+1)'(WAY);
   assign deq_fire   = deq_ready && !flush;

   always_comb begin
      for (int i = 0; i < WAY; i++)
         deq_phy[i] = mem_q[head_q + deq_off[i]];
   end

   always_comb begin
      mem_d = mem_q;
      for (int i = 0; i < WAY; i++)
         if (enq_valid[i]) mem_d[tail_q + enq_off[i]] = enq_phy[i];
      tail_d = tail_q + enq_cnt[PRF_WIDTH-1:0];
      ret_d  = ret_q + ca_cnt[PRF_WIDTH-1:0];
      head_d = head_q;
      free_count_d = free_count_q + enq_cnt;
      if (flush) begin
         // Rollback: everything past the committed allocations is free again.
         head_d       = ret_d;
         free_count_d = {1'b0, tail_d - ret_d};
      end else if (deq_fire) begin
         head_d       = head_q + deq_cnt[PRF_WIDTH-1:0];
         free_count_d = free_count_q + enq_cnt - deq_cnt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < PRF_ENTRY; i++)
            mem_q[i] <= (i == PRF_ENTRY-1) ? '0 : PRF_WIDTH'(i+1);
         head_q       <= '0;
         ret_q        <= '0;
         tail_q       <= PRF_WIDTH'(PRF_ENTRY-1);
         free_count_q <= (PRF_WIDTH+1)'(PRF_ENTRY-1);
      end else begin
         mem_q        <= mem_d;
         head_q       <= head_d;
         ret_q        <= ret_d;
         tail_q       <= tail_d;
         free_count_q <= free_count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !flush)
         assert (int'(free_count_q) + int'(enq_cnt) - (deq_fire ? int'(deq_cnt) : 0)
                 <= PRF_ENTRY-1)
         else $error("free_list overflow: enqueue past capacity");
   end

endmodule

// File: tb/tb_free_list.sv
// Scoreboard bench for free_list: a tag-queue model predicts grants and counts.
module tb_free_list;
   logic            clk = 1'b0;
   logic            rst;
   logic [1:0]      deq_req, enq_valid, commit_alloc;
   logic [1:0][5:0] deq_phy, enq_phy;
   logic            deq_ready, flush;
   logic [6:0]      free_count;

   int vectors = 0;
   int errors  = 0;
   int free_q[$];
   int alloc_q[$];
   int exp_q[$];

   free_list #(.PRF_ENTRY(64), .PRF_WIDTH(6), .WAY(2)) dut (
      .clk(clk), .rst(rst), .deq_req(deq_req), .deq_phy(deq_phy),
      .deq_ready(deq_ready), .enq_valid(enq_valid), .enq_phy(enq_phy),
      .commit_alloc(commit_alloc), .flush(flush), .free_count(free_count)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      free_q.delete();
      alloc_q.delete();
      exp_q.delete();
      for (int t = 1; t < 64; t++) free_q.push_back(t);
   endtask

   task automatic idle();
      deq_req = '0; enq_valid = '0; enq_phy = '0; commit_alloc = '0; flush = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      idle();
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One clock: drive at negedge, check outputs mid-low-phase, advance model.
   task automatic cycle(input logic [1:0] dq, input logic [1:0] ev, input int e0,
                        input int e1, input logic [1:0] ca, input logic fl);
      logic exp_rdy;
      int   tag;
      @(negedge clk);
      deq_req = dq; enq_valid = ev; commit_alloc = ca; flush = fl;
      enq_phy[0] = 6'(e0);
      enq_phy[1] = 6'(e1);
      #1;
      vectors++;
      if (free_count !== 7'(free_q.size())) begin
         errors++;
         $display("FAIL free_count: got %0d want %0d", free_count, free_q.size());
      end
      exp_rdy = free_q.size() >= 2;
      vectors++;
      if (deq_ready !== exp_rdy) begin
         errors++;
         $display("FAIL deq_ready: got %b want %b", deq_ready, exp_rdy);
      end
      if (exp_rdy && !fl) begin
         for (int i = 0; i < 2; i++) if (dq[i]) exp_q.push_back(free_q.pop_front());
         for (int i = 0; i < 2; i++) if (dq[i]) begin
            tag = exp_q.pop_front();
            vectors++;
            if (deq_phy[i] !== 6'(tag)) begin
               errors++;
               $display("FAIL deq_phy[%0d]: got %0d want %0d", i, deq_phy[i], tag);
            end
            alloc_q.push_back(tag);
         end
      end
      for (int i = 0; i < 2; i++) if (ca[i] && alloc_q.size() > 0) void'(alloc_q.pop_front());
      if (fl) begin
         for (int k = alloc_q.size()-1; k >= 0; k--) free_q.push_front(alloc_q[k]);
         alloc_q.delete();
      end
      if (ev[0]) free_q.push_back(e0);
      if (ev[1]) free_q.push_back(e1);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      model_reset();
      deq_req = 2'b11;
      #2;
      vectors++;
      if (free_count !== 7'd63 || deq_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_state: count=%0d ready=%b want 63/1", free_count, deq_ready);
      end
      vectors++;
      if (deq_phy[0] !== 6'd1 || deq_phy[1] !== 6'd2) begin
         errors++;
         $display("FAIL reset_head: got %0d,%0d want 1,2", deq_phy[0], deq_phy[1]);
      end
      @(negedge clk);
      rst = 1'b0;
      idle();
   endtask

   task automatic test_pair();
      do_reset();
      cycle(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
      cycle(2'b00, 2'b00, 0, 0, 2'b00, 1'b0);
      vectors++;
      if (free_count !== 7'd61) begin
         errors++;
         $display("FAIL pair_count: got %0d want 61", free_count);
      end
   endtask

   task automatic test_compaction();
      do_reset();
      cycle(2'b10, 2'b00, 0, 0, 2'b00, 1'b0);
      cycle(2'b00, 2'b00, 0, 0, 2'b00, 1'b0);
      vectors++;
      if (free_count !== 7'd62) begin
         errors++;
         $display("FAIL compact_count: got %0d want 62", free_count);
      end
   endtask

   task automatic test_enq_deq_and_empty();
      do_reset();
      for (int n = 0; n < 29; n++) cycle(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
      cycle(2'b11, 2'b11, 40, 41, 2'b00, 1'b0);
      vectors++;
      if (deq_phy[0] !== 6'd59 || deq_phy[1] !== 6'd60) begin
         errors++;
         $display("FAIL same_cycle_grant: got %0d,%0d want 59,60", deq_phy[0], deq_phy[1]);
      end
      cycle(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
      cycle(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
      cycle(2'b01, 2'b00, 0, 0, 2'b00, 1'b0);
      cycle(2'b00, 2'b01, 7, 0, 2'b00, 1'b0);
      cycle(2'b01, 2'b00, 0, 0, 2'b00, 1'b0);
      vectors++;
      if (deq_ready !== 1'b1 || deq_phy[0] !== 6'd41) begin
         errors++;
         $display("FAIL refill_grant: ready=%b tag=%0d want 1/41", deq_ready, deq_phy[0]);
      end
   endtask

   task automatic test_flush();
      do_reset();
      cycle(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
      cycle(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
      cycle(2'b00, 2'b00, 0, 0, 2'b11, 1'b0);
      cycle(2'b00, 2'b01, 9, 0, 2'b00, 1'b1);
      cycle(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
      vectors++;
      if (free_count !== 7'd62 || deq_phy[0] !== 6'd3 || deq_phy[1] !== 6'd4) begin
         errors++;
         $display("FAIL flush_rollback: count=%0d tags=%0d,%0d want 62 3,4",
                  free_count, deq_phy[0], deq_phy[1]);
      end
   endtask

   task automatic test_random();
      logic [1:0] dq, ev, ca;
      logic       fl;
      int         room, n;
      do_reset();
      for (int it = 0; it < 300; it++) begin
         dq   = 2'($urandom_range(0, 3));
         n    = $urandom_range(0, (alloc_q.size() < 2) ? alloc_q.size() : 2);
         ca   = (n == 2) ? 2'b11 : (n == 1) ? 2'($urandom_range(1, 2)) : 2'b00;
         room = 63 - free_q.size() - alloc_q.size();
         n    = $urandom_range(0, (room < 2) ? room : 2);
         ev   = (n == 2) ? 2'b11 : (n == 1) ? 2'($urandom_range(1, 2)) : 2'b00;
         fl   = ($urandom_range(0, 9) == 0);
         cycle(dq, ev, $urandom_range(1, 63), $urandom_range(1, 63), ca, fl);
      end
      cycle(2'b00, 2'b00, 0, 0, 2'b00, 1'b0);
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int n = 0; n < 4; n++) cycle(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
      @(posedge clk);
      #2;
      idle();
      deq_req = 2'b01;
      rst = 1'b1;
      #1;
      vectors++;
      if (free_count !== 7'd63 || deq_ready !== 1'b1 || deq_phy[0] !== 6'd1) begin
         errors++;
         $display("FAIL async_reset: count=%0d ready=%b tag=%0d want 63/1/1",
                  free_count, deq_ready, deq_phy[0]);
      end
      #1;
      rst = 1'b0;
      model_reset();
      cycle(2'b01, 2'b00, 0, 0, 2'b00, 1'b0);
      cycle(2'b00, 2'b00, 0, 0, 2'b00, 1'b0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_pair();
      test_compaction();
      test_enq_deq_and_empty();
      test_flush();
      test_random();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 Parameters (name, default, meaning): PRF_ENTRY, 64, physical registers; PRF_WIDTH, $clog2(PRF_ENTRY), tag width; WAY, from rv32i_types, superscalar width.
REQ-002 clk  in  1  sole clock.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 deq_req  in  WAY  rename slot i requests one free physical register.
REQ-005 deq_phy  out  PRF_WIDTH x WAY  tag granted to slot i; valid only when deq_req[i] and deq_ready.
REQ-006 deq_ready  out  1  free_count >= WAY; all-or-nothing grant.
REQ-007 enq_valid  in  WAY  retire slot i frees enq_phy[i]; driven by the retired RAT commit_phy_reg_valid.
REQ-008 enq_phy  in  PRF_WIDTH x WAY  stale tag freed at commit; driven by the retired RAT rd_phy.
REQ-009 commit_alloc  in  WAY  committing slot i had been allocated a tag at rename.
REQ-010 flush  in  1  mispredict recovery, single-cycle pulse.
REQ-011 free_count  out  PRF_WIDTH+1  registered count of free tags.

Function
REQ-012 Storage: circular buffer of PRF_ENTRY tag slots; head, tail and retired_head pointers, PRF_WIDTH bits, wrap modulo PRF_ENTRY.
REQ-013 Dequeue is compacted: slot i receives mem[head + number of set deq_req below i]; no gaps between grants.
REQ-014 deq_phy is combinational from registered mem/head; no state change unless deq_ready.
REQ-015 Dequeue fires when deq_ready=1 and flush=0; head advances by popcount(deq_req).
REQ-016 Enqueue is compacted: enq_phy[i] is written to mem[tail + number of set enq_valid below i]; tail advances by popcount(enq_valid).
REQ-017 Enqueue is never back-pressured; tag 0 is never enqueued (the retired RAT already masks it).
REQ-018 retired_head advances by popcount(commit_alloc) every cycle, flush or not.
REQ-019 No bypass: tags enqueued in cycle N are grantable no earlier than cycle N+1.
REQ-020 Simultaneous enqueue and dequeue: both apply; free_count_next = free_count + popcount(enq_valid) - popcount(granted).
REQ-021 Flush: dequeue suppressed; enqueue and retired_head update still apply; head_next = retired_head_next.
REQ-022 Flush: free_count_next = (tail_next - head_next) mod PRF_ENTRY.
REQ-023 Empty or short: free_count < WAY forces deq_ready=0; partial grants are forbidden.
REQ-024 Overflow: an enqueue that would make free_count exceed PRF_ENTRY-1 is illegal and SHALL fire a simulation assertion.

Reset
REQ-025 Asynchronous reset, effective immediately, with no clock required.
REQ-026 Reset values: mem[i] = i+1 for i = 0..PRF_ENTRY-2; mem[PRF_ENTRY-1] = 0; head = 0; retired_head = 0; tail = PRF_ENTRY-1; free_count = PRF_ENTRY-1.
REQ-027 Tag 0 is permanently held by the reset architectural mapping and is never in the list.
REQ-028 Reset asserted mid-operation discards all in-flight state; the first grant after release is tag 1.

Structure
REQ-029 WAY, PRF_ENTRY and the phys-tag typedef live in rv32i_types; free_list declares no new global constants.
REQ-030 No sub-module: prefix-offset and popcount logic is inline, iterated over WAY.

Verification (WAY=2)
REQ-031 Post-reset: deq_req=2'b11 -> deq_phy={1,2}, deq_ready=1; next cycle free_count=61.
REQ-032 Compaction: deq_req=2'b10 after reset -> deq_phy[1]=1; next free_count=62.
REQ-033 Enqueue and dequeue in the same cycle: enq_valid=2'b11, enq_phy={40,41}, deq_req=2'b11 from a list holding 5 tags -> grants are the two oldest tags, not 40 or 41; next free_count=5.
REQ-034 Empty: drain to free_count=1, then deq_req=2'b01 -> deq_ready=0, no head movement; enqueue 7 -> next cycle deq_ready=1.
REQ-035 Flush: from reset, rename 4 tags (1-4) and commit_alloc the first 2; flush with enq_valid=2'b01, enq_phy=9 -> head returns to 2; next grant={3,4}; free_count=62.
REQ-036 Async reset pulse between clock edges mid-stream -> outputs take reset values immediately; after release, deq_phy[0]=1.
